// File: rtl/md_unit_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The master drives the operation request; the slave returns status and HI/LO.
interface md_unit_if;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// Operands are captured at launch; the result is committed after a fixed latency.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_MULT  = 4'b0001,
    OP_MULTU = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_DIVU  = 4'b0100,
    OP_MTHI  = 4'b0101,
    OP_MTLO  = 4'b0110
  } md_op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0]      rs_q, rt_q;
  logic             signed_q;
  logic             latch_en;
  logic             latch_signed;

  // Datapath working from the latched operands only.
  logic [63:0] mul_a, mul_b, product;
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_mag, dvs_mag, dvs_safe;
  logic [31:0] quo_mag, rem_mag, quo, rem;
  logic        div_by_zero;

  always_comb begin
    mul_a   = signed_q ? {{32{rs_q[31]}}, rs_q} : {32'd0, rs_q};
    mul_b   = signed_q ? {{32{rt_q[31]}}, rt_q} : {32'd0, rt_q};
    product = mul_a * mul_b;

    // Signed division goes through magnitudes so that 0x80000000 / -1 wraps
    // to 0x80000000 instead of relying on an overflowing signed divide.
    dvd_neg     = signed_q & rs_q[31];
    dvs_neg     = signed_q & rt_q[31];
    dvd_mag     = dvd_neg ? (32'd0 - rs_q) : rs_q;
    dvs_mag     = dvs_neg ? (32'd0 - rt_q) : rt_q;
    div_by_zero = (rt_q == 32'd0);
    dvs_safe    = div_by_zero ? 32'd1 : dvs_mag;
    quo_mag     = dvd_mag / dvs_safe;
    rem_mag     = dvd_mag % dvs_safe;
    quo         = (dvd_neg ^ dvs_neg) ? (32'd0 - quo_mag) : quo_mag;
    rem         = dvd_neg ? (32'd0 - rem_mag) : rem_mag;
  end

  // Next-state and output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    hi_d         = hi_q;
    lo_d         = lo_q;
    latch_en     = 1'b0;
    latch_signed = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md_op_e'(md.md_op))
            OP_MULT, OP_MULTU: begin
              state_d      = MULT;
              cnt_d        = CNT_W'(MULT_CYCLES);
              busy_d       = 1'b1;
              latch_en     = 1'b1;
              latch_signed = (md.md_op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d      = DIV;
              cnt_d        = CNT_W'(DIV_CYCLES);
              busy_d       = 1'b1;
              latch_en     = 1'b1;
              latch_signed = (md.md_op == OP_DIV);
            end
            OP_MTHI: hi_d = md.rs_val;
            OP_MTLO: lo_d = md.rs_val;
            default: ;
          endcase
        end
      end

      MULT, DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (state_q == MULT) begin
            hi_d = product[63:32];
            lo_d = product[31:0];
          end else if (!div_by_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so all
  // flops sample their inputs from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: operand latches carry no reset; they are always written at launch
  // before being consumed, and a capture during reset is never used.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      rs_q     <= md.rs_val;
      rt_q     <= md.rt_val;
      signed_q <= latch_signed;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: stimulus pushes expected HI/LO and completion
// cycle into a scoreboard; a monitor pops and compares on every done pulse.
module tb_md_unit_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  md_unit_if bus ();

  md_unit_ctrl #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns the cycle number right after that edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lc);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    step();
    bus.start  = 1'b0;
    bus.md_op  = OP_NOP;
    lc = cyc;
  endtask

  task automatic expect_result(input logic [31:0] h, input logic [31:0] l, input int at);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.at = at;
    sb.push_back(e);
  endtask

  // Walk the busy window: busy must stay high n cycles while hi/lo hold, then
  // drop with done. With noise, an mthi request is held on start throughout.
  task automatic busy_run(input int n, input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                          input bit noise);
    for (int i = 0; i < n; i++) begin
      check($sformatf("busy_high[%0d]", i), {31'd0, bus.busy}, 32'd1);
      check($sformatf("done_low[%0d]", i), {31'd0, bus.done}, 32'd0);
      check($sformatf("hi_hold[%0d]", i), bus.hi, hold_hi);
      check($sformatf("lo_hold[%0d]", i), bus.lo, hold_lo);
      if (noise) begin
        bus.start  = 1'b1;
        bus.md_op  = OP_MTHI;
        bus.rs_val = 32'h12345678;
      end else begin
        bus.rs_val = $urandom;
      end
      bus.rt_val = $urandom;
      step();
    end
    bus.start = 1'b0;
    bus.md_op = OP_NOP;
    check("busy_fall", {31'd0, bus.busy}, 32'd0);
    check("done_pulse", {31'd0, bus.done}, 32'd1);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.at));
          check("result_hi", bus.hi, e.hi);
          check("result_lo", bus.lo, e.lo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lc;
    logic [3:0] undef_ops [3];
    undef_ops[0] = 4'h0;
    undef_ops[1] = 4'h7;
    undef_ops[2] = 4'hF;

    bus.start  = 1'b0;
    bus.md_op  = OP_NOP;
    bus.rs_val = '0;
    bus.rt_val = '0;

    // Reset, with a competing mthi request that must lose.
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.md_op  = OP_MTHI;
    bus.rs_val = 32'hAAAA5555;
    step();
    step();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.md_op = OP_NOP;
    step();

    // Signed mult (-2 * 3) with mthi held on start while busy.
    issue(OP_MULT, 32'hFFFFFFFE, 32'h00000003, lc);
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFA, lc + MC);
    busy_run(MC, 32'h0, 32'h0, 1'b1);

    // mthi in the done cycle is accepted.
    issue(OP_MTHI, 32'h12345678, 32'h0, lc);
    check("mthi_done_hi", bus.hi, 32'h12345678);
    check("mthi_done_lo", bus.lo, 32'hFFFFFFFA);
    check("mthi_done_busy", {31'd0, bus.busy}, 32'd0);
    check("mthi_done_done", {31'd0, bus.done}, 32'd0);

    // Unsigned mult of all-ones.
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lc);
    expect_result(32'hFFFFFFFE, 32'h00000001, lc + MC);
    busy_run(MC, 32'h12345678, 32'hFFFFFFFA, 1'b0);
    step();
    check("done_single", {31'd0, bus.done}, 32'd0);

    // mtlo while idle, then undefined opcodes that must change nothing.
    issue(OP_MTLO, 32'hCAFEF00D, 32'h0, lc);
    check("mtlo_lo", bus.lo, 32'hCAFEF00D);
    check("mtlo_hi", bus.hi, 32'hFFFFFFFE);
    check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    foreach (undef_ops[k]) begin
      issue(undef_ops[k], 32'hDEADBEEF, 32'h1, lc);
      check($sformatf("undef_hi[%0d]", k), bus.hi, 32'hFFFFFFFE);
      check($sformatf("undef_lo[%0d]", k), bus.lo, 32'hCAFEF00D);
      check($sformatf("undef_busy[%0d]", k), {31'd0, bus.busy}, 32'd0);
    end

    // div -7 / 2, then back-to-back divu 7/0, then back-to-back mult.
    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, lc);
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD, lc + DC);
    busy_run(DC, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b1);

    issue(OP_DIVU, 32'h00000007, 32'h00000000, lc);
    expect_result(32'hFFFFFFFF, 32'hFFFFFFFD, lc + DC);
    busy_run(DC, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    issue(OP_MULT, 32'h00000007, 32'hFFFFFFFD, lc);
    expect_result(32'hFFFFFFFF, 32'hFFFFFFEB, lc + MC);
    busy_run(MC, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    // Signed-division corner cases and an unsigned divide.
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lc);
    expect_result(32'h00000000, 32'h80000000, lc + DC);
    busy_run(DC, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

    issue(OP_DIV, 32'h00000007, 32'hFFFFFFFE, lc);
    expect_result(32'h00000001, 32'hFFFFFFFD, lc + DC);
    busy_run(DC, 32'h00000000, 32'h80000000, 1'b0);

    issue(OP_DIVU, 32'hFFFFFFFF, 32'h00000010, lc);
    expect_result(32'h0000000F, 32'h0FFFFFFF, lc + DC);
    busy_run(DC, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    step();

    // Reset in the 4th busy cycle of a div aborts it without a done pulse.
    issue(OP_DIV, 32'd100, 32'd7, lc);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_busy[%0d]", i), {31'd0, bus.busy}, 32'd1);
      step();
    end
    check("abort_busy[3]", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    repeat (DC + 4) step();
    check("abort_hi_after", bus.hi, 32'h0);
    check("abort_lo_after", bus.lo, 32'h0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
